// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared PS/2 definitions: host-transmit FSM encoding, frame
//                length, common keyboard command bytes, parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_INHIBIT   = 3'd1;
    localparam logic [2:0] c_ST_REQ       = 3'd2;
    localparam logic [2:0] c_ST_SEND      = 3'd3;
    localparam logic [2:0] c_ST_ACK       = 3'd4;
    localparam logic [2:0] c_ST_WAIT_IDLE = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = c_ST_IDLE,
        ST_INHIBIT   = c_ST_INHIBIT,
        ST_REQ       = c_ST_REQ,
        ST_SEND      = c_ST_SEND,
        ST_ACK       = c_ST_ACK,
        ST_WAIT_IDLE = c_ST_WAIT_IDLE
    } ps2_tx_state_t;

    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // Odd parity: the bit that makes the total count of ones odd.
    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_line_filter
//  Description : 2-flop synchroniser for PS/2 clock and data, FILTER_LEN glitch
//                filter on the clock, one-cycle falling-edge strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clk_pin,
    input  logic i_data_pin,
    output logic o_clk_filt,
    output logic o_data_sync,
    output logic o_clk_fall
);

    localparam int                c_CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(FILTER_LEN - 1);

    logic [1:0]         r_clk_sync;
    logic [1:0]         r_data_sync;
    logic               r_clk_filt;
    logic               r_fall;
    logic [c_CNT_W-1:0] r_cnt;

    // Idle bus level is high, so the synchronisers reset to 1 to avoid a
    // spurious edge when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_filt  <= 1'b1;
            r_fall      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_clk_pin};
            r_data_sync <= {r_data_sync[0], i_data_pin};
            r_fall      <= 1'b0;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_LAST) begin
                r_clk_filt <= r_clk_sync[1];
                r_fall     <= r_clk_filt;
                r_cnt      <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_clk_filt  = r_clk_filt;
    assign o_data_sync = r_data_sync[1];
    assign o_clk_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device command transmitter with open-drain line
//                drive, device ACK check and inter-edge timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       Fast_Clock,
    input  logic       Reset_N,
    input  logic       Tx_Start,
    input  logic [7:0] Tx_Byte,
    output logic       Tx_Busy,
    output logic       Tx_Done,
    output logic       Tx_Err,
    output logic       Rx_Inhibit,
    input  logic       KB_Clk_In,
    input  logic       KB_Data_In,
    output logic       KB_Clk_Drive_Low,
    output logic       KB_Data_Drive_Low
);

    localparam int c_CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_INHIBIT_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         c_STOP_IDX     = 4'(PS2_FRAME_BITS - 1);

    logic w_clk_filt, w_data_sync, w_fall;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk         (Fast_Clock),
        .rst_n       (Reset_N),
        .i_clk_pin   (KB_Clk_In),
        .i_data_pin  (KB_Data_In),
        .o_clk_filt  (w_clk_filt),
        .o_data_sync (w_data_sync),
        .o_clk_fall  (w_fall)
    );

    ps2_tx_state_t      r_state, w_state_nxt;
    logic [9:0]         r_shift, w_shift_nxt;
    logic [3:0]         r_bit_idx, w_bit_idx_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_tx_low, w_tx_low_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;
    logic               w_timeout;

    always_ff @(posedge Fast_Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_cnt     <= '0;
            r_tx_low  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tx_low  <= w_tx_low_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign w_timeout = (r_cnt >= c_TIMEOUT_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_tx_low_nxt  = r_tx_low;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_cnt_nxt     = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
        if (w_fall) begin
            w_cnt_nxt = '0;
        end

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                // A request arriving alongside the previous frame's pulse is dropped.
                if (Tx_Start && !r_done && !r_err) begin
                    w_state_nxt   = ST_INHIBIT;
                    w_shift_nxt   = {1'b1, ps2_odd_parity(Tx_Byte), Tx_Byte};
                    w_bit_idx_nxt = '0;
                    w_tx_low_nxt  = 1'b0;
                end
            end
            ST_INHIBIT: begin
                if (r_cnt == c_INHIBIT_LAST) begin
                    w_state_nxt = ST_REQ;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_REQ, ST_SEND: begin
                if (w_timeout) begin
                    w_state_nxt  = ST_IDLE;
                    w_tx_low_nxt = 1'b0;
                    w_err_nxt    = 1'b1;
                end else if (w_fall) begin
                    if (r_state == ST_SEND && r_bit_idx == c_STOP_IDX) begin
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_state_nxt   = ST_SEND;
                        w_tx_low_nxt  = ~r_shift[0];
                        w_shift_nxt   = {1'b1, r_shift[9:1]};
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                    end
                end
            end
            ST_ACK: begin
                w_tx_low_nxt = 1'b0;
                if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end else if (!w_data_sync) begin
                    w_state_nxt = ST_WAIT_IDLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end else if (w_clk_filt && w_data_sync) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_tx_low_nxt = 1'b0;
            end
        endcase
    end

    assign Tx_Busy          = (r_state != ST_IDLE);
    assign Rx_Inhibit       = Tx_Busy;
    assign Tx_Done          = r_done;
    assign Tx_Err           = r_err;
    assign KB_Clk_Drive_Low = (r_state == ST_INHIBIT);
    // Start bit is asserted in the last inhibit cycle so data is low before clock is released.
    assign KB_Data_Drive_Low = ((r_state == ST_INHIBIT) && (r_cnt == c_INHIBIT_LAST))
                             || (r_state == ST_REQ)
                             || ((r_state == ST_SEND) && r_tx_low);

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Self-checking bench for ps2_host_tx with a PS/2 device model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH       = 60;
    localparam int TMO       = 1500;
    localparam int FLT       = 8;
    localparam int HALF      = 25;
    localparam int START_DLY = 50;

    logic       Fast_Clock = 1'b0;
    logic       Reset_N    = 1'b0;
    logic       Tx_Start   = 1'b0;
    logic [7:0] Tx_Byte    = 8'h00;
    logic       Tx_Busy, Tx_Done, Tx_Err, Rx_Inhibit;
    logic       KB_Clk_In, KB_Data_In, KB_Clk_Drive_Low, KB_Data_Drive_Low;
    logic       bfm_clk  = 1'b1;
    logic       bfm_data = 1'b1;

    int checks = 0, failures = 0, cyc = 0;
    int n_done = 0, n_err = 0, n_both = 0, n_inh_mis = 0, busy_at_pulse = 0, last_err_cyc = 0;

    assign KB_Clk_In  = bfm_clk  & ~KB_Clk_Drive_Low;
    assign KB_Data_In = bfm_data & ~KB_Data_Drive_Low;

    always #5 Fast_Clock = ~Fast_Clock;
    always @(posedge Fast_Clock) cyc <= cyc + 1;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .Fast_Clock        (Fast_Clock),
        .Reset_N           (Reset_N),
        .Tx_Start          (Tx_Start),
        .Tx_Byte           (Tx_Byte),
        .Tx_Busy           (Tx_Busy),
        .Tx_Done           (Tx_Done),
        .Tx_Err            (Tx_Err),
        .Rx_Inhibit        (Rx_Inhibit),
        .KB_Clk_In         (KB_Clk_In),
        .KB_Data_In        (KB_Data_In),
        .KB_Clk_Drive_Low  (KB_Clk_Drive_Low),
        .KB_Data_Drive_Low (KB_Data_Drive_Low)
    );

    always @(negedge Fast_Clock) begin
        if (Tx_Done) n_done <= n_done + 1;
        if (Tx_Err) begin
            n_err        <= n_err + 1;
            last_err_cyc <= cyc;
        end
        if (Tx_Done && Tx_Err) n_both <= n_both + 1;
        if ((Tx_Done || Tx_Err) && Tx_Busy) busy_at_pulse <= busy_at_pulse + 1;
        if (Rx_Inhibit !== Tx_Busy) n_inh_mis <= n_inh_mis + 1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Frame as the device sees it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] b);
        @(negedge Fast_Clock);
        Tx_Byte  = b;
        Tx_Start = 1'b1;
        @(negedge Fast_Clock);
        Tx_Start = 1'b0;
    endtask

    // Device model: measures inhibit, clocks the frame, samples on rising edges.
    // stop_at=0 returns at clock release; stop_at=k stops with clock low after fall k.
    task automatic bfm_frame(input int stop_at, input logic ack, input int inj_bit,
                             output logic [10:0] got, output int inh_len, output logic start_low);
        int guard;
        got = '0; inh_len = 0; start_low = 1'b0; guard = 0;
        while (!KB_Clk_Drive_Low && guard < 50) begin
            @(negedge Fast_Clock);
            guard++;
        end
        while (KB_Clk_Drive_Low && guard < 20000) begin
            inh_len++;
            start_low = KB_Data_Drive_Low;
            @(negedge Fast_Clock);
            guard++;
        end
        if (stop_at == 0) return;
        repeat (START_DLY) @(negedge Fast_Clock);
        got[0] = KB_Data_In;
        for (int i = 1; i <= 10; i++) begin
            bfm_clk = 1'b0;
            if (i == stop_at) begin
                repeat (HALF / 2) @(negedge Fast_Clock);
                return;
            end
            repeat (HALF) @(negedge Fast_Clock);
            bfm_clk = 1'b1;
            got[i]  = KB_Data_In;
            if (i == inj_bit) begin
                repeat (12) @(negedge Fast_Clock);
                Tx_Byte  = 8'h55;
                Tx_Start = 1'b1;
                @(negedge Fast_Clock);
                Tx_Start = 1'b0;
                bfm_clk  = 1'b0;
                repeat (3) @(negedge Fast_Clock);
                bfm_clk  = 1'b1;
                repeat (HALF - 16) @(negedge Fast_Clock);
            end else begin
                repeat (HALF) @(negedge Fast_Clock);
            end
        end
        bfm_data = ack;
        repeat (5) @(negedge Fast_Clock);
        bfm_clk = 1'b0;
        repeat (HALF) @(negedge Fast_Clock);
        bfm_clk = 1'b1;
        repeat (5) @(negedge Fast_Clock);
        bfm_data = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] b, input int inj_bit, input bit start_in_pulse);
        logic [10:0] got;
        int          inh, k;
        logic        sl, d, e;
        d = 1'b0; e = 1'b0;
        start_tx(b);
        bfm_frame(11, 1'b0, inj_bit, got, inh, sl);
        k = 0;
        while (!(Tx_Done || Tx_Err) && k < 100) begin
            @(negedge Fast_Clock);
            k++;
        end
        d = Tx_Done; e = Tx_Err;
        if (start_in_pulse) begin
            Tx_Byte  = 8'hAA;
            Tx_Start = 1'b1;
        end
        @(negedge Fast_Clock);
        Tx_Start = 1'b0;
        chk($sformatf("frame_bits_%02h", b), 32'(got), 32'(exp_frame(b)));
        chk($sformatf("inhibit_len_%02h", b), 32'(inh), 32'(INH));
        chk($sformatf("start_low_%02h", b), 32'(sl), 32'd1);
        chk($sformatf("done_err_%02h", b), 32'({d, e}), 32'b10);
        chk($sformatf("done_one_cycle_%02h", b), 32'(Tx_Done), 32'd0);
        repeat (3) @(negedge Fast_Clock);
        chk($sformatf("idle_lines_busy_%02h", b),
            32'({KB_Clk_Drive_Low, KB_Data_Drive_Low, Tx_Busy}), 32'b000);
    endtask

    initial begin
        logic [10:0] got;
        int          inh, k, e0, d0, t0;
        logic        sl;

        repeat (3) @(negedge Fast_Clock);
        chk("reset_outputs", 32'({Tx_Busy, Tx_Done, Tx_Err, Rx_Inhibit, KB_Clk_Drive_Low, KB_Data_Drive_Low}), 32'd0);
        Reset_N = 1'b1;
        repeat (3) @(negedge Fast_Clock);

        run_frame(PS2_CMD_SET_LEDS, -1, 1'b1);
        run_frame(8'h00, -1, 1'b0);
        run_frame(8'h01, -1, 1'b0);
        run_frame(PS2_CMD_RESET, -1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_frame(8'($urandom_range(0, 255)), -1, 1'b0);
        end

        // Device NACK
        e0 = n_err; d0 = n_done;
        start_tx(8'($urandom_range(0, 255)));
        bfm_frame(11, 1'b1, -1, got, inh, sl);
        repeat (20) @(negedge Fast_Clock);
        chk("nack_err_count", 32'(n_err - e0), 32'd1);
        chk("nack_no_done", 32'(n_done - d0), 32'd0);
        chk("nack_busy_low", 32'(Tx_Busy), 32'd0);
        run_frame(PS2_CMD_ECHO, -1, 1'b0);

        // Silent device
        e0 = n_err;
        start_tx(PS2_CMD_ENABLE);
        bfm_frame(0, 1'b0, -1, got, inh, sl);
        t0 = cyc;
        k  = 0;
        while (n_err == e0 && k < TMO + 50) begin
            @(negedge Fast_Clock);
            k++;
        end
        @(negedge Fast_Clock);
        chk("timeout_err_count", 32'(n_err - e0), 32'd1);
        chk("timeout_latency", 32'(last_err_cyc - t0), 32'(TMO));
        chk("timeout_lines", 32'({KB_Clk_Drive_Low, KB_Data_Drive_Low}), 32'd0);

        // Mid-frame request plus clock glitch
        run_frame(PS2_CMD_SET_LEDS, 4, 1'b0);

        // Reset while D3 is on the line
        start_tx(PS2_CMD_SET_LEDS);
        bfm_frame(4, 1'b0, -1, got, inh, sl);
        chk("pre_reset_busy", 32'(Tx_Busy), 32'd1);
        Reset_N = 1'b0;
        #1;
        chk("reset_mid_frame", 32'({KB_Clk_Drive_Low, KB_Data_Drive_Low, Tx_Busy}), 32'd0);
        bfm_clk = 1'b1;
        repeat (5) @(negedge Fast_Clock);
        Reset_N = 1'b1;
        repeat (5) @(negedge Fast_Clock);
        run_frame(PS2_CMD_ENABLE, -1, 1'b0);

        chk("never_done_and_err", 32'(n_both), 32'd0);
        chk("busy_low_in_pulse", 32'(busy_at_pulse), 32'd0);
        chk("rx_inhibit_tracks_busy", 32'(n_inh_mis), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
